// File: rtl/mips_jump_pkg.sv
// Shared constants and result type for J-type jump field encoding.
package mips_jump_pkg;

  localparam int unsigned JIDX_W      = 26;
  localparam int unsigned REGION_MSB  = 31;
  localparam int unsigned REGION_LSB  = 28;
  localparam logic [31:0] REGION_MASK = 32'hF000_0000;

  // Payload held in both the output register and the skid register.
  typedef struct packed {
    logic [JIDX_W-1:0] index;
    logic              err_align;
    logic              err_region;
  } jfe_result_t;

  // Encode a (pc, target) pair into the J-type index plus error flags.
  function automatic jfe_result_t jfe_encode(input logic [31:0] pc, input logic [31:0] target);
    jfe_result_t r;
    r.index      = target[JIDX_W+1:2];
    r.err_align  = |target[1:0];
    r.err_region = (target[REGION_MSB:REGION_LSB] != pc[REGION_MSB:REGION_LSB]);
    return r;
  endfunction

endpackage

// File: rtl/jfe_skid_slice.sv
// One-entry skid buffer behind a registered output stage, carrying jfe_result_t.
// in_ready is a decode of the state register only, so there is no path from out_ready.
module jfe_skid_slice
  import mips_jump_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  jfe_result_t in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output jfe_result_t out_data
);

  typedef enum logic [1:0] {StEmpty, StFull, StFullSkid} state_e;

  state_e      state_q, state_d;
  jfe_result_t out_q, out_d;
  jfe_result_t skid_q, skid_d;
  logic        accept;

  assign in_ready  = (state_q != StFullSkid);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = out_q;
  assign accept    = in_valid && in_ready;

  // Next-state and payload movement for the output/skid pair.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          out_d   = in_data;
          state_d = StFull;
        end
      end
      StFull: begin
        if (out_ready) begin
          if (accept) out_d = in_data;
          else        state_d = StEmpty;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = StFullSkid;
        end
      end
      StFullSkid: begin
        if (out_ready) begin
          out_d   = skid_q;
          state_d = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State and payload registers; reset discards any held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/jump_field_encoder.sv
// Encodes (pc, target) into the 26-bit J-type index with alignment/region error flags.
// Optional statistics counters are built only when JFE_STATS_EN is defined.
module jump_field_encoder
  import mips_jump_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [JIDX_W-1:0] out_index,
  output logic              out_err_align,
  output logic              out_err_region
`ifdef JFE_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt_ok,
  output logic [CNT_W-1:0]  cnt_err
`endif
);

  jfe_result_t enc;
  jfe_result_t res;

  assign enc = jfe_encode(in_pc, in_target);

  jfe_skid_slice u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (enc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (res)
  );

  assign out_index      = res.index;
  assign out_err_align  = res.err_align;
  assign out_err_region = res.err_region;

`ifdef JFE_STATS_EN
  logic             out_hs;
  logic             res_err;
  logic [CNT_W-1:0] cnt_ok_q, cnt_err_q;

  assign out_hs  = out_valid && out_ready;
  assign res_err = res.err_align || res.err_region;

  // Saturating counts of delivered results, split by error status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else if (out_hs) begin
      if (!res_err && (cnt_ok_q != '1))  cnt_ok_q  <= cnt_ok_q + 1'b1;
      if (res_err && (cnt_err_q != '1))  cnt_err_q <= cnt_err_q + 1'b1;
    end
  end

  assign cnt_ok  = cnt_ok_q;
  assign cnt_err = cnt_err_q;
`endif

endmodule

// File: tb/tb_jump_field_encoder.sv
// Directed and randomized checks for jump_field_encoder.
module tb_jump_field_encoder;

`ifdef JFE_STATS_EN
  localparam int unsigned CW = 4;
`else
  localparam int unsigned CW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [25:0] out_index;
  logic        out_err_align;
  logic        out_err_region;
  logic [CW-1:0] cnt_ok, cnt_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jump_field_encoder #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_target      (in_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_index      (out_index),
    .out_err_align  (out_err_align),
    .out_err_region (out_err_region)
`ifdef JFE_STATS_EN
    ,
    .cnt_ok         (cnt_ok),
    .cnt_err        (cnt_err)
`endif
  );

`ifndef JFE_STATS_EN
  assign cnt_ok  = '0;
  assign cnt_err = '0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    // Fill output and skid, then reset asynchronously between edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h0000_0000;
    in_target = 32'h0000_0100;
    step();
    in_target = 32'h0000_0200;
    step();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_prefill in_ready got %b want 0", in_ready);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 26'h0 ||
        out_err_align !== 1'b0 || out_err_region !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got v=%b r=%b idx=%h a=%b g=%b want v=0 r=1 idx=0 a=0 g=0",
               out_valid, in_ready, out_index, out_err_align, out_err_region);
    end
`ifdef JFE_STATS_EN
    n_cmp++;
    if (cnt_ok !== '0 || cnt_err !== '0) begin
      n_bad++; $display("FAIL reset_cnt got ok=%0d err=%0d want 0 0", cnt_ok, cnt_err);
    end
`endif
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    // Discarded entries must never reappear.
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_discard out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h0040_0004;
    in_target = 32'h0040_0020;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_index !== 26'h010_0008 || out_err_align !== 1'b0 ||
        out_err_region !== 1'b0) begin
      n_bad++;
      $display("FAIL basic got v=%b idx=%h a=%b g=%b want v=1 idx=0100008 a=0 g=0",
               out_valid, out_index, out_err_align, out_err_region);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_drain out_valid got %b want 0", out_valid);
    end
`ifdef JFE_STATS_EN
    n_cmp++;
    if (cnt_ok !== 4'd1 || cnt_err !== 4'd0) begin
      n_bad++; $display("FAIL basic_cnt got ok=%0d err=%0d want 1 0", cnt_ok, cnt_err);
    end
`endif
  endtask

  task automatic test_errors();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h1000_0000;
    in_target = 32'h2000_0010;
    step();
    n_cmp++;
    if (out_index !== 26'h000_0004 || out_err_align !== 1'b0 || out_err_region !== 1'b1) begin
      n_bad++;
      $display("FAIL err_region got idx=%h a=%b g=%b want idx=0000004 a=0 g=1",
               out_index, out_err_align, out_err_region);
    end
    in_pc     = 32'h0000_0000;
    in_target = 32'h0000_0006;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_index !== 26'h000_0001 || out_err_align !== 1'b1 || out_err_region !== 1'b0) begin
      n_bad++;
      $display("FAIL err_align got idx=%h a=%b g=%b want idx=0000001 a=1 g=0",
               out_index, out_err_align, out_err_region);
    end
    step();
`ifdef JFE_STATS_EN
    n_cmp++;
    if (cnt_ok !== 4'd0 || cnt_err !== 4'd2) begin
      n_bad++; $display("FAIL err_cnt got ok=%0d err=%0d want 0 2", cnt_ok, cnt_err);
    end
`endif
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_pc     = 32'h3000_0000;
      in_target = 32'h3000_0000 + 32'(i * 4 + 32'h40);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_index !== 26'(i + 16)) begin
        n_bad++;
        $display("FAIL b2b[%0d] got v=%b r=%b idx=%h want v=1 r=1 idx=%h",
                 i, out_valid, in_ready, out_index, 26'(i + 16));
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h0000_0000;
    in_target = 32'h0000_0A00;  // idx 0x280
    step();
    in_target = 32'h0000_0B00;  // idx 0x2C0
    step();
    n_cmp++;
    if (out_index !== 26'h280 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL stall_skid got idx=%h r=%b want idx=280 r=0", out_index, in_ready);
    end
    in_target = 32'h0000_0C00;  // idx 0x300, must stall
    step();
    n_cmp++;
    if (out_index !== 26'h280 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_hold got idx=%h r=%b v=%b want idx=280 r=0 v=1",
               out_index, in_ready, out_valid);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_index !== 26'h2C0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_drain1 got idx=%h r=%b want idx=2c0 r=1", out_index, in_ready);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_index !== 26'h300 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_drain2 got idx=%h v=%b want idx=300 v=1", out_index, out_valid);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_empty out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] e;
    logic [31:0] pc, tg;
    logic        ea, er;
    int          hs = 0, eok = 0, eerr = 0, guard;
    int          maxc = (1 << CW) - 1;
    apply_reset();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      in_target = $urandom;
      if ($urandom_range(0, 1) == 1)
        in_target = (in_pc & 32'hF000_0000) | (in_target & 32'h0FFF_FFFC);
      #2;
      if (in_valid && in_ready) q.push_back({in_pc, in_target});
      if (out_valid && out_ready) begin
        hs++;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL rand_spurious result idx=%h with empty model", out_index);
        end else begin
          e  = q.pop_front();
          pc = e[63:32];
          tg = e[31:0];
          ea = (tg[1:0] != 2'b00);
          er = (tg[31:28] != pc[31:28]);
          if (ea || er) eerr++; else eok++;
          if (out_err_align !== ea || out_err_region !== er || out_index !== tg[27:2]) begin
            n_bad++;
            $display("FAIL rand pc=%h tg=%h got idx=%h a=%b g=%b want idx=%h a=%b g=%b",
                     pc, tg, out_index, out_err_align, out_err_region, tg[27:2], ea, er);
          end else if (!ea && !er &&
                       (({4'h0, out_index, 2'b00} | (pc & 32'hF000_0000)) !== tg)) begin
            n_bad++; $display("FAIL rand_recon pc=%h tg=%h idx=%h", pc, tg, out_index);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (out_valid && guard < 10) begin
      e  = q.pop_front();
      tg = e[31:0];
      pc = e[63:32];
      hs++;
      if ((tg[1:0] != 2'b00) || (tg[31:28] != pc[31:28])) eerr++; else eok++;
      step();
      guard++;
    end
    n_cmp++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rand_drain left=%0d out_valid=%b want 0 0", q.size(), out_valid);
    end
`ifdef JFE_STATS_EN
    n_cmp++;
    if (int'(cnt_ok) != ((eok > maxc) ? maxc : eok) ||
        int'(cnt_err) != ((eerr > maxc) ? maxc : eerr)) begin
      n_bad++;
      $display("FAIL rand_cnt got ok=%0d err=%0d want %0d %0d (hs=%0d)", cnt_ok, cnt_err,
               (eok > maxc) ? maxc : eok, (eerr > maxc) ? maxc : eerr, hs);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_back_to_back();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
